a5_1_stream_decrypt: RTL and testbench
======================================

Name: a5_1_stream_decrypt

Overview:
- Receive-side counterpart of the A5/1 keystream cipher: bit-serial decryptor.
- Loads a 64-bit session key and a 22-bit frame number, then runs multi-cycle initialisation at one LFSR step per clock.
- Then XORs an incoming ciphertext bit stream with the keystream and emits plaintext, using valid/ready handshakes on both sides.
- Sits between the burst deframer (ciphertext source) and the payload sink. One frame per start pulse.

Parameters:
- KS_LEN, 114, keystream/payload bits per frame.
- MIX_CYCLES, 100, majority-clocked discard steps after loading.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- key  in  64  session key; key[i] is loaded at step i; sampled on accepted start.
- frame  in  22  frame number; frame[i] is loaded at step i; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- cipher_valid  in  1  ciphertext bit valid.
- cipher_bit  in  1  ciphertext bit.
- cipher_ready  out  1  decryptor accepts a ciphertext bit.
- plain_valid  out  1  plaintext bit valid.
- plain_bit  out  1  plaintext bit.
- plain_last  out  1  qualifies the KS_LEN-th plaintext bit.
- plain_ready  in  1  sink accepts a plaintext bit.
- done  out  1  one-cycle pulse after the last plaintext bit is accepted.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; R1, R2, R3 and all counters go to 0.
  - Outputs busy, cipher_ready, plain_valid, plain_bit, plain_last and done all go to 0.
  - Reset mid-frame abandons the frame; no done is issued.
- Registers: R1 19b, taps 13,16,17,18, clock bit 8. R2 22b, taps 20,21, clock bit 10. R3 23b, taps 7,20,21,22, clock bit 10.
- Step: shift left; bit0 takes the XOR of the taps, XORed with the input bit when loading. Output = R1[18]^R2[21]^R3[22].
- FSM: IDLE -> LOAD_KEY -> LOAD_FRAME -> MIX -> RUN -> IDLE.
  - IDLE: on start, latch key and frame, clear registers, go to LOAD_KEY.
  - LOAD_KEY: 64 cycles; all three registers step every cycle with key[i], i=0..63.
  - LOAD_FRAME: 22 cycles, same rule with frame[i].
  - MIX: MIX_CYCLES cycles of majority clocking. maj = majority of the three clock bits; a register steps iff its clock bit == maj. No output is produced.
  - RUN: cipher_ready = !plain_valid || plain_ready.
    - On cipher_valid && cipher_ready: majority-step first, then plain_bit <= cipher_bit ^ output computed on the post-step register values.
    - Also plain_valid <= 1, and plain_last <= 1 when this is accepted bit number KS_LEN.
  - Plaintext accept: when plain_valid && plain_ready and no new bit is loaded in the same cycle, plain_valid <= 0. Simultaneous accept and load keeps plain_valid=1 (full throughput, 1 bit/cycle).
  - Leaving RUN: after KS_LEN bits have been accepted on the cipher side, cipher_ready drops. When the last plaintext bit is accepted, pulse done and go to IDLE. busy falls in the same cycle done is high.
- Latency: the first cipher_ready is asserted exactly 64+22+MIX_CYCLES = 186 cycles after the accepted start edge. Each plaintext bit follows its ciphertext bit by 1 cycle.
- Keystream does not advance when no handshake occurs; backpressure stalls it with no bit lost or duplicated.
- plain_bit and plain_last hold stable while plain_valid && !plain_ready.
- start while busy: ignored; key and frame are not re-sampled.

Decomposition:
- Package a5_1_pkg holds:
  - register lengths 19/22/23;
  - tap masks 19'h72000, 22'h300000, 23'h700080;
  - clock-bit indices 8/10/10;
  - constants KEY_BITS=64, FRAME_BITS=22;
  - state enum {IDLE, LOAD_KEY, LOAD_FRAME, MIX, RUN}.
- Sub-module a5_1_lfsr_core:
  - contains the three registers;
  - inputs clr, step_all, step_maj, in_bit;
  - output ks_bit (combinational from current state).
- The top level holds the FSM, counters and handshake.

Test Plan:
- Reference vector: key=64'hEFCDAB8967452312, frame=22'h134, 114 ciphertext zeros, plain_ready=1 -> plaintext equals bytes 53 4E AA 58 2F E8 15 1A B6 E1 85 5A 72 8C (112 bits, MSB first), then final bits 0,0. plain_last on bit 114; done pulses once.
- Latency: start at cycle T -> first cipher_ready at T+186. Plaintext bit 0 valid at acceptance+1.
- Backpressure: same vector with plain_ready toggled pseudo-randomly and cipher_valid gapped -> identical 114-bit sequence, no drops or duplicates, outputs stable while stalled.
- Involution: feed the test-1 keystream as ciphertext, same key/frame -> 114 zero plaintext bits.
- start pulsed during MIX and RUN -> ignored, output unchanged. rst_n=0 for 1 cycle mid-RUN -> all outputs 0, state IDLE, no done; a new start then reproduces test 1.
- Back-to-back frames: second start in the cycle after done with frame=22'h135 -> busy reasserts and a fresh 186-cycle init runs; keystream differs from test 1.

Source files
------------

// File: rtl/a5_1_pkg.sv
// Shared constants, state encoding and helpers for the A5/1 stream decryptor.
package a5_1_pkg;

  localparam int unsigned R1_LEN = 19;
  localparam int unsigned R2_LEN = 22;
  localparam int unsigned R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int unsigned R1_CLK = 8;
  localparam int unsigned R2_CLK = 10;
  localparam int unsigned R3_CLK = 10;

  localparam int unsigned KEY_BITS   = 64;
  localparam int unsigned FRAME_BITS = 22;

  // Wide enough for step counts up to 255 and payload lengths up to 255.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    RUN
  } state_e;

  // Majority of three bits.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_1_stream_decrypt_if.sv
// Control, ciphertext-in and plaintext-out signals of the decryptor.
interface a5_1_stream_decrypt_if;
  import a5_1_pkg::*;

  logic                  start;
  logic [KEY_BITS-1:0]   key;
  logic [FRAME_BITS-1:0] frame;
  logic                  busy;
  logic                  cipher_valid;
  logic                  cipher_bit;
  logic                  cipher_ready;
  logic                  plain_valid;
  logic                  plain_bit;
  logic                  plain_last;
  logic                  plain_ready;
  logic                  done;

  // Environment side: drives control, ciphertext and sink readiness.
  modport master (
    output start, key, frame, cipher_valid, cipher_bit, plain_ready,
    input  busy, cipher_ready, plain_valid, plain_bit, plain_last, done
  );

  // Decryptor side.
  modport slave (
    input  start, key, frame, cipher_valid, cipher_bit, plain_ready,
    output busy, cipher_ready, plain_valid, plain_bit, plain_last, done
  );

endinterface

// File: rtl/a5_1_lfsr_core.sv
// The three A5/1 LFSRs with clear, lock-step load and majority stepping.
module a5_1_lfsr_core
  import a5_1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic step_all_i,
  input  logic step_maj_i,
  input  logic in_bit_i,
  output logic ks_bit_c
);

  logic [R1_LEN-1:0] r1_q, r1_d, r1_all, r1_maj;
  logic [R2_LEN-1:0] r2_q, r2_d, r2_all, r2_maj;
  logic [R3_LEN-1:0] r3_q, r3_d, r3_all, r3_maj;
  logic              maj;

  assign maj = maj3(r1_q[R1_CLK], r2_q[R2_CLK], r3_q[R3_CLK]);

  // Lock-step values: every register shifts, input bit folded into feedback.
  assign r1_all = {r1_q[R1_LEN-2:0], (^(r1_q & R1_TAPS)) ^ in_bit_i};
  assign r2_all = {r2_q[R2_LEN-2:0], (^(r2_q & R2_TAPS)) ^ in_bit_i};
  assign r3_all = {r3_q[R3_LEN-2:0], (^(r3_q & R3_TAPS)) ^ in_bit_i};

  // Majority-clocked values: only registers whose clock bit agrees shift.
  assign r1_maj = (r1_q[R1_CLK] == maj) ? {r1_q[R1_LEN-2:0], ^(r1_q & R1_TAPS)} : r1_q;
  assign r2_maj = (r2_q[R2_CLK] == maj) ? {r2_q[R2_LEN-2:0], ^(r2_q & R2_TAPS)} : r2_q;
  assign r3_maj = (r3_q[R3_CLK] == maj) ? {r3_q[R3_LEN-2:0], ^(r3_q & R3_TAPS)} : r3_q;

  // Keystream bit produced by the next majority step (post-step output).
  assign ks_bit_c = r1_maj[R1_LEN-1] ^ r2_maj[R2_LEN-1] ^ r3_maj[R3_LEN-1];

  // Next register contents; clear wins over stepping.
  always_comb begin
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    if (clr_i) begin
      r1_d = '0;
      r2_d = '0;
      r3_d = '0;
    end else if (step_all_i) begin
      r1_d = r1_all;
      r2_d = r2_all;
      r3_d = r3_all;
    end else if (step_maj_i) begin
      r1_d = r1_maj;
      r2_d = r2_maj;
      r3_d = r3_maj;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  end

endmodule

// File: rtl/a5_1_stream_decrypt.sv
// Bit-serial A5/1 decryptor: key/frame load, mixing, then handshaked XOR stream.
module a5_1_stream_decrypt
  import a5_1_pkg::*;
#(
  parameter int unsigned KS_LEN     = 114,
  parameter int unsigned MIX_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  a5_1_stream_decrypt_if.slave  io
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  busy_q, busy_d;
  logic                  plain_valid_q, plain_valid_d;
  logic                  plain_bit_q, plain_bit_d;
  logic                  plain_last_q, plain_last_d;
  logic                  done_q, done_d;

  logic clr, step_all, step_maj, in_bit, ks_bit_c;
  logic cipher_ready_c, load, accept;

  a5_1_lfsr_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .step_all_i (step_all),
    .step_maj_i (step_maj),
    .in_bit_i   (in_bit),
    .ks_bit_c   (ks_bit_c)
  );

  assign io.busy         = busy_q;
  assign io.cipher_ready = cipher_ready_c;
  assign io.plain_valid  = plain_valid_q;
  assign io.plain_bit    = plain_bit_q;
  assign io.plain_last   = plain_last_q;
  assign io.done         = done_q;

  // Next-state, LFSR control and handshake logic.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    key_d          = key_q;
    frame_d        = frame_q;
    busy_d         = busy_q;
    plain_valid_d  = plain_valid_q;
    plain_bit_d    = plain_bit_q;
    plain_last_d   = plain_last_q;
    done_d         = 1'b0;
    clr            = 1'b0;
    step_all       = 1'b0;
    step_maj       = 1'b0;
    in_bit         = 1'b0;
    cipher_ready_c = 1'b0;
    load           = 1'b0;
    accept         = plain_valid_q && io.plain_ready;

    case (state_q)
      IDLE: begin
        if (io.start) begin
          key_d      = io.key;
          frame_d    = io.frame;
          clr        = 1'b1;
          step_cnt_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        // Key bits are consumed LSB first by shifting the latched copy.
        step_all = 1'b1;
        in_bit   = key_q[0];
        key_d    = key_q >> 1;
        if (step_cnt_q == CNT_W'(KEY_BITS - 1)) begin
          step_cnt_d = '0;
          state_d    = LOAD_FRAME;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end
      LOAD_FRAME: begin
        step_all = 1'b1;
        in_bit   = frame_q[0];
        frame_d  = frame_q >> 1;
        if (step_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          step_cnt_d = '0;
          state_d    = MIX;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end
      MIX: begin
        step_maj = 1'b1;
        if (step_cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
          step_cnt_d = '0;
          state_d    = RUN;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cipher_ready_c = (bit_cnt_q != CNT_W'(KS_LEN)) && (!plain_valid_q || io.plain_ready);
        load           = io.cipher_valid && cipher_ready_c;
        if (load) begin
          // Keystream advances only on an accepted ciphertext bit.
          step_maj      = 1'b1;
          plain_bit_d   = io.cipher_bit ^ ks_bit_c;
          plain_valid_d = 1'b1;
          plain_last_d  = (bit_cnt_q == CNT_W'(KS_LEN - 1));
          bit_cnt_d     = bit_cnt_q + CNT_W'(1);
        end else if (accept) begin
          plain_valid_d = 1'b0;
          plain_last_d  = 1'b0;
          if (plain_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      step_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      key_q         <= '0;
      frame_q       <= '0;
      busy_q        <= 1'b0;
      plain_valid_q <= 1'b0;
      plain_bit_q   <= 1'b0;
      plain_last_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      key_q         <= key_d;
      frame_q       <= frame_d;
      busy_q        <= busy_d;
      plain_valid_q <= plain_valid_d;
      plain_bit_q   <= plain_bit_d;
      plain_last_q  <= plain_last_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_a5_1_stream_decrypt.sv
// Self-checking bench for a5_1_stream_decrypt: vector table plus corner sequences.
module tb_a5_1_stream_decrypt;
  import a5_1_pkg::*;

  localparam int unsigned KS    = 114;
  localparam int          BOUND = 2500;
  localparam logic [0:113] REF_KS = {112'h534EAA582FE8151AB6E1855A728C, 2'b00};
  localparam logic [63:0]  REF_KEY = 64'hEFCDAB8967452312;

  typedef struct {
    string        name;
    logic [63:0]  key;
    logic [21:0]  frame;
    logic [0:113] cipher;
    bit           bp;
    bit           poke;
    logic [0:113] exp_plain;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  a5_1_stream_decrypt_if io();

  a5_1_stream_decrypt #(.KS_LEN(KS), .MIX_CYCLES(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int total = 0;
  int bad   = 0;
  int unsigned m_reg [3];
  vec_t tbl [6];

  task automatic chk_int(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [0:113] got, input logic [0:113] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference model: registers held as plain integers, stepped arithmetically.
  function automatic void m_clock(input int j, input bit in_b);
    int unsigned mask [3] = '{32'h72000, 32'h300000, 32'h700080};
    int          len  [3] = '{19, 22, 23};
    bit fb;
    fb = (^(m_reg[j] & mask[j])) ^ in_b;
    m_reg[j] = ((m_reg[j] << 1) | {31'd0, fb}) & ((32'd1 << len[j]) - 32'd1);
  endfunction

  function automatic void m_majority();
    int cb [3] = '{8, 10, 10};
    bit b [3];
    int ones;
    bit mj;
    ones = 0;
    for (int j = 0; j < 3; j++) begin
      b[j] = m_reg[j][cb[j]];
      ones += int'(b[j]);
    end
    mj = (ones >= 2);
    for (int j = 0; j < 3; j++) if (b[j] == mj) m_clock(j, 1'b0);
  endfunction

  function automatic logic [0:113] model_ks(input logic [63:0] k, input logic [21:0] f);
    logic [0:113] ks;
    bit b;
    ks = '0;
    for (int j = 0; j < 3; j++) m_reg[j] = 0;
    for (int i = 0; i < 86; i++) begin
      b = (i < 64) ? k[i] : f[i-64];
      for (int j = 0; j < 3; j++) m_clock(j, b);
    end
    for (int i = 0; i < 100; i++) m_majority();
    for (int i = 0; i < 114; i++) begin
      m_majority();
      ks[i] = m_reg[0][18] ^ m_reg[1][21] ^ m_reg[2][22];
    end
    return ks;
  endfunction

  // Runs one frame from an idle DUT, observing all handshakes at negedges.
  task automatic run_frame(input logic [63:0] k, input logic [21:0] f,
                           input logic [0:113] c, input bit bp, input bit poke,
                           input int tail,
                           output logic [0:113] got, output int nbits,
                           output int last_err, output int ndone,
                           output int stall_err, output int lat,
                           output int busy0, output int busy_done);
    int  ci, tailc;
    bit  prev_stall;
    logic prev_bit, prev_last;
    got = '0; nbits = 0; last_err = 0; ndone = 0; stall_err = 0;
    lat = -1; busy0 = 0; busy_done = 0;
    ci = 0; tailc = 0; prev_stall = 0; prev_bit = 0; prev_last = 0;
    @(negedge clk);
    io.start = 1'b1; io.key = k; io.frame = f;
    io.cipher_valid = 1'b0; io.plain_ready = 1'b1;
    for (int cyc = 0; cyc < BOUND; cyc++) begin
      @(negedge clk);
      io.start = poke && (cyc == 120 || cyc == 200 || cyc == 250);
      io.key   = {$urandom, $urandom};
      io.frame = 22'($urandom);
      io.cipher_valid = (ci < 114) && (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
      io.cipher_bit   = (ci < 114) ? c[ci] : 1'b0;
      io.plain_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) busy0 = int'(io.busy);
      if (io.cipher_ready && lat < 0) lat = cyc;
      if (io.done) begin
        ndone++;
        busy_done = int'(io.busy);
      end
      if (prev_stall && (!io.plain_valid || io.plain_bit !== prev_bit || io.plain_last !== prev_last))
        stall_err++;
      prev_stall = io.plain_valid && !io.plain_ready;
      prev_bit   = io.plain_bit;
      prev_last  = io.plain_last;
      if (io.plain_valid && io.plain_ready) begin
        if (nbits < 114) got[nbits] = io.plain_bit;
        if (io.plain_last !== (nbits == 113)) last_err++;
        nbits++;
      end
      if (io.cipher_valid && io.cipher_ready) ci++;
      if (ndone > 0) begin
        if (tailc >= tail) break;
        tailc++;
      end
    end
    io.start = 1'b0; io.cipher_valid = 1'b0; io.plain_ready = 1'b1;
  endtask

  task automatic do_vec(input vec_t v, input int tail, output logic [0:113] got);
    int nbits, last_err, ndone, stall_err, lat, busy0, busy_done;
    run_frame(v.key, v.frame, v.cipher, v.bp, v.poke, tail,
              got, nbits, last_err, ndone, stall_err, lat, busy0, busy_done);
    chk_vec({v.name, " plaintext"}, got, v.exp_plain);
    chk_int({v.name, " bit count"}, nbits, 114);
    chk_int({v.name, " plain_last placement errors"}, last_err, 0);
    chk_int({v.name, " done pulses"}, ndone, 1);
    chk_int({v.name, " stall stability errors"}, stall_err, 0);
    chk_int({v.name, " first cipher_ready latency"}, lat, 186);
    chk_int({v.name, " busy after start"}, busy0, 1);
    chk_int({v.name, " busy during done"}, busy_done, 0);
  endtask

  initial begin
    logic [0:113] got, got2, rc;
    logic [63:0]  rk;
    logic [21:0]  rf;
    vec_t v;
    int cnt;

    io.start = 1'b0; io.key = '0; io.frame = '0;
    io.cipher_valid = 1'b0; io.cipher_bit = 1'b0; io.plain_ready = 1'b1;

    tbl[0] = '{"ref_vector", REF_KEY, 22'h134, '0, 1'b0, 1'b0, REF_KS};
    tbl[1] = '{"ref_backpressure", REF_KEY, 22'h134, '0, 1'b1, 1'b0, REF_KS};
    tbl[2] = '{"involution", REF_KEY, 22'h134, REF_KS, 1'b1, 1'b0, '0};
    tbl[3] = '{"start_ignored_mix_run", REF_KEY, 22'h134, '0, 1'b0, 1'b1, REF_KS};
    for (int t = 4; t < 6; t++) begin
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      for (int i = 0; i < 114; i++) rc[i] = 1'($urandom);
      tbl[t] = '{(t == 4) ? "random_bp" : "random_full", rk, rf, rc, (t == 4), 1'b0,
                 rc ^ model_ks(rk, rf)};
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_int("reset outputs", int'({io.busy, io.cipher_ready, io.plain_valid,
                                  io.plain_bit, io.plain_last, io.done}), 0);

    for (int t = 0; t < 6; t++) do_vec(tbl[t], 3, got);

    // Reset for one cycle in the middle of RUN.
    @(negedge clk);
    io.start = 1'b1; io.key = REF_KEY; io.frame = 22'h134;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      io.start = 1'b0; io.cipher_valid = 1'b1; io.cipher_bit = 1'b0; io.plain_ready = 1'b1;
    end
    #1;
    chk_int("plain_valid before mid-run reset", int'(io.plain_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_int("outputs after mid-run reset", int'({io.busy, io.cipher_ready, io.plain_valid,
                                               io.plain_bit, io.plain_last, io.done}), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (io.done || io.plain_valid || io.busy) cnt++;
    end
    chk_int("activity after mid-run reset", cnt, 0);
    io.cipher_valid = 1'b0;
    v = tbl[0];
    v.name = "after_reset";
    do_vec(v, 3, got);

    // Back-to-back frames: second start in the cycle after done.
    v.name = "b2b_first";
    do_vec(v, 0, got);
    v.name = "b2b_second";
    v.frame = 22'h135;
    v.exp_plain = model_ks(REF_KEY, 22'h135);
    do_vec(v, 3, got2);
    chk_int("b2b keystream differs from frame 0x134", int'(got2 != REF_KS), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
